cntr_sampler: RTL and testbench

Free-running counter with periodic sampling into a small FIFO, exposed as a valid/ready stream. It sits directly downstream of the simple counter datapath: it turns the raw counter into a paced sample stream that a logging or checking consumer drains at its own rate. Dropped samples are flagged by a sticky overflow bit.

---
 rtl/cntr_sampler_pkg.sv | 15 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/cntr_sampler.sv | 87 ++++++++
 tb/tb_cntr_sampler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cntr_sampler_pkg.sv
// cntr_sampler_pkg: shared types and helpers for the counter sampler.
//   clog2_depth : width needed to hold an occupancy count of 0..depth
//   sample_t    : sample word at the default counter width
package cntr_sampler_pkg;

    localparam int unsigned SAMPLE_W = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Occupancy runs 0..depth inclusive, so one more value than the depth.
    function automatic int unsigned clog2_depth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with synchronous flush.
//   clock, reset_n : clock and asynchronous active-low reset
//   i_flush        : empties the FIFO; wins over push and pop
//   i_push/i_push_data : write request; accepted when not full or when popping
//   i_pop          : read request; ignored while empty
//   o_data         : head entry, valid while !o_empty
//   o_full/o_empty/o_level : occupancy status
module sync_fifo
    import cntr_sampler_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = clog2_depth(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/cntr_sampler.sv
// cntr_sampler: free-running counter sampled every PERIOD enabled cycles into a FIFO,
// presented as a valid/ready stream with a sticky drop flag.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous clear of counter, timer, FIFO and overflow
//   enable         : advances counter and period timer
//   cnt_o          : current counter value
//   smp_data/smp_valid/smp_ready : sample stream (show-ahead)
//   level          : FIFO occupancy
//   overflow       : sticky, set when a sample is dropped
module cntr_sampler
    import cntr_sampler_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned PERIOD     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                clear,
    input  logic                                enable,
    output logic [CNT_WIDTH-1:0]                cnt_o,
    output logic [CNT_WIDTH-1:0]                smp_data,
    output logic                                smp_valid,
    input  logic                                smp_ready,
    output logic [clog2_depth(FIFO_DEPTH)-1:0]  level,
    output logic                                overflow
);

    localparam int unsigned LVL_W = clog2_depth(FIFO_DEPTH);
    // Keep at least one timer bit so PERIOD = 1 still elaborates.
    localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_overflow;

    logic w_fire;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_fire = enable & ~clear & (r_timer == TMR_W'(PERIOD - 1));
    assign w_pop  = smp_valid & smp_ready & ~clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_cnt      <= '0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (enable) begin
                r_cnt   <= r_cnt + CNT_WIDTH'(1);
                r_timer <= w_fire ? '0 : r_timer + TMR_W'(1);
            end
            // Drop only when full and the head is not leaving this edge.
            if (w_fire && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (CNT_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_flush     (clear),
        .i_push      (w_fire),
        .i_push_data (r_cnt),
        .i_pop       (w_pop),
        .o_data      (smp_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level)
    );

    assign smp_valid = ~w_empty;
    assign cnt_o     = r_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cntr_sampler.sv
// tb_cntr_sampler: directed self-checking bench for cntr_sampler (defaults 4/3/4).
module tb_cntr_sampler;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic       enable;
    logic [3:0] cnt_o;
    logic [3:0] smp_data;
    logic       smp_valid;
    logic       smp_ready;
    logic [2:0] level;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    cntr_sampler #(
        .CNT_WIDTH  (4),
        .PERIOD     (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .enable    (enable),
        .cnt_o     (cnt_o),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .level     (level),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and samples move 1ns after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the bench 1ns after an edge; the next edge is enabled edge 1.
    task automatic do_reset();
        reset_n   = 1'b0;
        clear     = 1'b0;
        enable    = 1'b0;
        smp_ready = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_cnt", 32'(cnt_o), 0);
        check("rst_valid", 32'(smp_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", 32'(smp_data), 0);

        // 1: continuous stream with ready high
        enable    = 1'b1;
        smp_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(2);
            check("s1_pre_valid", 32'(smp_valid), 0);
            tick(1);
            check("s1_valid", 32'(smp_valid), 1);
            check("s1_data", 32'(smp_data), 32'((3 * k - 1) % 16));
        end
        check("s1_ovf", 32'(overflow), 0);

        // 2: back-pressure from reset, drop, then drain
        do_reset();
        enable = 1'b1;
        tick(12);
        check("s2_level_full", 32'(level), 4);
        check("s2_head", 32'(smp_data), 2);
        check("s2_ovf_pre", 32'(overflow), 0);
        tick(3);
        check("s2_level_hold", 32'(level), 4);
        check("s2_ovf", 32'(overflow), 1);
        check("s2_head_stable", 32'(smp_data), 2);
        smp_ready = 1'b1;
        tick(1);
        check("s2_d5", 32'(smp_data), 5);
        tick(1);
        check("s2_d8", 32'(smp_data), 8);
        tick(1);
        check("s2_d11", 32'(smp_data), 11);
        check("s2_lvl_pp", 32'(level), 2);
        tick(1);
        check("s2_d1", 32'(smp_data), 1);
        tick(1);
        check("s2_empty", 32'(smp_valid), 0);
        check("s2_ovf_sticky", 32'(overflow), 1);

        // 3: pop coincides with the push into a full FIFO
        do_reset();
        enable = 1'b1;
        tick(14);
        check("s3_level", 32'(level), 4);
        smp_ready = 1'b1;
        tick(1);
        check("s3_level_pp", 32'(level), 4);
        check("s3_ovf", 32'(overflow), 0);
        check("s3_head", 32'(smp_data), 5);
        tick(2);
        check("s3_d11", 32'(smp_data), 11);
        tick(1);
        check("s3_d14", 32'(smp_data), 14);
        tick(1);
        check("s3_d1", 32'(smp_data), 1);

        // 4: enable low for 5 cycles after sample 2
        do_reset();
        enable    = 1'b1;
        smp_ready = 1'b1;
        tick(3);
        check("s4_d2", 32'(smp_data), 2);
        enable = 1'b0;
        tick(5);
        check("s4_cnt_hold", 32'(cnt_o), 3);
        check("s4_no_fire", 32'(smp_valid), 0);
        enable = 1'b1;
        tick(2);
        check("s4_early", 32'(smp_valid), 0);
        tick(1);
        check("s4_valid", 32'(smp_valid), 1);
        check("s4_d5", 32'(smp_data), 5);

        // 5: clear with 3 buffered and overflow set
        do_reset();
        enable = 1'b1;
        tick(15);
        smp_ready = 1'b1;
        tick(1);
        smp_ready = 1'b0;
        check("s5_level3", 32'(level), 3);
        check("s5_ovf_pre", 32'(overflow), 1);
        clear     = 1'b1;
        smp_ready = 1'b1;
        tick(1);
        clear     = 1'b0;
        smp_ready = 1'b0;
        check("s5_level", 32'(level), 0);
        check("s5_valid", 32'(smp_valid), 0);
        check("s5_ovf", 32'(overflow), 0);
        check("s5_cnt", 32'(cnt_o), 0);
        tick(2);
        check("s5_early", 32'(smp_valid), 0);
        tick(1);
        check("s5_valid2", 32'(smp_valid), 1);
        check("s5_d2", 32'(smp_data), 2);

        // 6: asynchronous reset mid-period with a full FIFO
        do_reset();
        enable = 1'b1;
        tick(12);
        check("s6_full", 32'(level), 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_valid", 32'(smp_valid), 0);
        check("s6_level", 32'(level), 0);
        check("s6_cnt", 32'(cnt_o), 0);
        tick(2);
        check("s6_hold_cnt", 32'(cnt_o), 0);
        check("s6_hold_level", 32'(level), 0);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
